avr_irq_ctrl: RTL and testbench

Parametrised interrupt controller for the AVR core. It replaces the fixed 4-input combinational priority encoder with up to 8 synchronised IRQ inputs, each with per-channel enable, edge/level mode and polarity. It provides pending latches, fixed or round-robin arbitration, and a registered `iflag`/`ivect` pair to the core. Software configures it through an MMIO register window decoded by the MMIO block; the core acknowledges taken interrupts with the vector number.

---
 rtl/avr_irq_ctrl_pkg.sv | 28 ++
 rtl/avr_irq_ctrl_if.sv | 24 ++
 rtl/avr_irq_ctrl_sync.sv | 38 +++
 rtl/avr_irq_ctrl.sv | 144 ++++++++++++++
 tb/tb_avr_irq_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/avr_irq_ctrl_pkg.sv
// Shared definitions for the AVR interrupt controller: register map,
// CTRL bit positions and a constant-evaluable ceil(log2) helper.
package avr_irq_pkg;

  typedef enum logic [2:0] {
    IRQ_PEND   = 3'd0,
    IRQ_ENABLE = 3'd1,
    IRQ_MODE   = 3'd2,
    IRQ_POL    = 3'd3,
    IRQ_CTRL   = 3'd4,
    IRQ_RAW    = 3'd5,
    IRQ_RSV6   = 3'd6,
    IRQ_RSV7   = 3'd7
  } irq_reg_e;

  localparam int CTRL_GIE = 0;
  localparam int CTRL_RR  = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < value) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/avr_irq_ctrl_if.sv
// MMIO register bus plus the iflag/ivect/iack handshake towards the AVR core.
interface avr_irq_ctrl_if #(
  parameter int VECT_W = 2
);
  logic              reg_re;
  logic              reg_we;
  logic [2:0]        reg_a;
  logic [7:0]        reg_di;
  logic [7:0]        reg_do;
  logic              iflag;
  logic [VECT_W-1:0] ivect;
  logic              iack;
  logic [VECT_W-1:0] iack_vect;

  modport master (
    output reg_re, reg_we, reg_a, reg_di, iack, iack_vect,
    input  reg_do, iflag, ivect
  );

  modport slave (
    input  reg_re, reg_we, reg_a, reg_di, iack, iack_vect,
    output reg_do, iflag, ivect
  );
endinterface

// File: rtl/avr_irq_ctrl_sync.sv
// Single-channel 3-flop synchroniser; polarity is corrected ahead of the first
// flop so every stage resets to the inactive level and reset release is edge-free.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_raw,
  input  logic pol,
  output logic lvl,
  output logic rise
);

  logic s1_d, s2_d, s3_d;
  logic s1_q, s2_q, s3_q;

  // next-state of the synchroniser chain
  always_comb begin
    s1_d = irq_raw ^ ~pol;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // synchroniser flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign lvl  = s2_q;
  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/avr_irq_ctrl.sv
// AVR interrupt controller top: per-channel synchronisers, pending latches,
// MMIO register file and fixed/round-robin arbiter with registered outputs.
module avr_irq_ctrl
  import avr_irq_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int VECT_W  = 2
) (
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_IRQ-1:0] irq_in,
  avr_irq_ctrl_if.slave     bus
);

  logic [NUM_IRQ-1:0] en_d, en_q, mode_d, mode_q, pol_d, pol_q;
  logic [NUM_IRQ-1:0] pend_d, pend_q;
  logic               gie_d, gie_q, rr_d, rr_q;
  logic [VECT_W-1:0]  rr_ptr_d, rr_ptr_q;
  logic               iflag_d, iflag_q;
  logic [VECT_W-1:0]  ivect_d, ivect_q;
  logic [7:0]         reg_do_d, reg_do_q;

  logic [NUM_IRQ-1:0] lvl_s, rise_s, w1c_s, ack_s, cand_s;
  logic [7:0]         rd_s;
  logic               ack_ok_s, hit_s, take_s;
  logic [VECT_W-1:0]  idx_s, win_s;
  logic               unused_di_s;

  assign unused_di_s = ^bus.reg_di;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .irq_raw (irq_in[i]),
      .pol     (pol_q[i]),
      .lvl     (lvl_s[i]),
      .rise    (rise_s[i])
    );
  end

  // register writes; PEND writes only produce a clear mask
  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    pol_d  = pol_q;
    gie_d  = gie_q;
    rr_d   = rr_q;
    w1c_s  = '0;
    if (bus.reg_we) begin
      case (irq_reg_e'(bus.reg_a))
        IRQ_PEND:   w1c_s  = bus.reg_di[NUM_IRQ-1:0];
        IRQ_ENABLE: en_d   = bus.reg_di[NUM_IRQ-1:0];
        IRQ_MODE:   mode_d = bus.reg_di[NUM_IRQ-1:0];
        IRQ_POL:    pol_d  = bus.reg_di[NUM_IRQ-1:0];
        IRQ_CTRL: begin
          gie_d = bus.reg_di[CTRL_GIE];
          rr_d  = bus.reg_di[CTRL_RR];
        end
        default:    w1c_s  = '0;
      endcase
    end else begin
      w1c_s = '0;
    end
  end

  // read mux sampled from pre-write state
  always_comb begin
    rd_s = 8'h00;
    case (irq_reg_e'(bus.reg_a))
      IRQ_PEND:   rd_s[NUM_IRQ-1:0] = pend_q;
      IRQ_ENABLE: rd_s[NUM_IRQ-1:0] = en_q;
      IRQ_MODE:   rd_s[NUM_IRQ-1:0] = mode_q;
      IRQ_POL:    rd_s[NUM_IRQ-1:0] = pol_q;
      IRQ_CTRL: begin
        rd_s[CTRL_GIE] = gie_q;
        rd_s[CTRL_RR]  = rr_q;
      end
      IRQ_RAW:    rd_s[NUM_IRQ-1:0] = lvl_s;
      default:    rd_s = 8'h00;
    endcase
    reg_do_d = bus.reg_re ? rd_s : reg_do_q;
  end

  // pending update and arbitration; an edge set outranks any clear
  always_comb begin
    ack_ok_s = bus.iack && (int'(bus.iack_vect) < NUM_IRQ);
    ack_s    = '0;
    if (ack_ok_s) begin
      ack_s[bus.iack_vect] = 1'b1;
    end else begin
      ack_s = '0;
    end
    pend_d = (mode_q & ((pend_q & ~(w1c_s | ack_s)) | rise_s)) | (~mode_q & lvl_s);
    cand_s = pend_q & en_q & {NUM_IRQ{gie_q}};

    hit_s  = 1'b0;
    take_s = 1'b0;
    idx_s  = '0;
    win_s  = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      idx_s  = rr_q ? VECT_W'((int'(rr_ptr_q) + k) % NUM_IRQ) : VECT_W'(k);
      take_s = !hit_s && cand_s[idx_s];
      win_s  = take_s ? idx_s : win_s;
      hit_s  = hit_s | take_s;
    end

    rr_ptr_d = ack_ok_s ? VECT_W'((int'(bus.iack_vect) + 1) % NUM_IRQ) : rr_ptr_q;
    iflag_d  = |cand_s;
    ivect_d  = win_s;
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= '0;
      mode_q   <= '0;
      pol_q    <= '1;
      gie_q    <= 1'b0;
      rr_q     <= 1'b0;
      pend_q   <= '0;
      rr_ptr_q <= '0;
      iflag_q  <= 1'b0;
      ivect_q  <= '0;
      reg_do_q <= 8'h00;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      pol_q    <= pol_d;
      gie_q    <= gie_d;
      rr_q     <= rr_d;
      pend_q   <= pend_d;
      rr_ptr_q <= rr_ptr_d;
      iflag_q  <= iflag_d;
      ivect_q  <= ivect_d;
      reg_do_q <= reg_do_d;
    end
  end

  assign bus.iflag  = iflag_q;
  assign bus.ivect  = ivect_q;
  assign bus.reg_do = reg_do_q;

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Scoreboard bench for avr_irq_ctrl: a cycle-level reference model pushes the
// expected outputs and read data; a negedge monitor pops and compares them.
module tb_avr_irq_ctrl;
  import avr_irq_pkg::*;

  localparam int N  = 4;
  localparam int VW = (N > 1) ? clog2(N) : 1;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] mval;
    logic [7:0] cval;
    logic [7:0] cmask;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq_in;
  int            checks = 0;
  int            errors = 0;
  logic [7:0]    rd_cval, rd_cmask;

  logic [VW:0]   out_q[$];
  rd_exp_t       rd_q[$];

  logic [N-1:0]  m_s1, m_s2, m_s3, m_pend, m_en, m_mode, m_pol;
  logic          m_gie, m_rr;
  int            m_ptr;

  avr_irq_ctrl_if #(.VECT_W(VW)) bus ();

  avr_irq_ctrl #(.NUM_IRQ(N), .VECT_W(VW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_in (irq_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_s3 = '0; m_pend = '0;
    m_en = '0; m_mode = '0; m_pol = '1;
    m_gie = 1'b0; m_rr = 1'b0; m_ptr = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] a);
    logic [7:0] v;
    v = 8'h00;
    case (a)
      3'd0: v[N-1:0] = m_pend;
      3'd1: v[N-1:0] = m_en;
      3'd2: v[N-1:0] = m_mode;
      3'd3: v[N-1:0] = m_pol;
      3'd4: v[1:0]   = {m_rr, m_gie};
      3'd5: v[N-1:0] = m_s2;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // reference model, one step per clock from the register-level rules
  always @(posedge clk) begin
    if (!rst_n) begin
      m_reset();
      out_q.push_back('0);
    end else begin
      bit any;
      int win, ch;
      bit ack_ok, clr;
      logic [N-1:0] np;
      any = 1'b0; win = 0;
      for (int k = 0; k < N; k++) begin
        ch = m_rr ? (m_ptr + k) % N : k;
        if (!any && m_gie && m_pend[ch] && m_en[ch]) begin
          any = 1'b1; win = ch;
        end
      end
      out_q.push_back(any ? {1'b1, VW'(win)} : '0);
      if (bus.reg_re) begin
        rd_exp_t r;
        r.addr = bus.reg_a; r.mval = m_read(bus.reg_a);
        r.cval = rd_cval; r.cmask = rd_cmask;
        rd_q.push_back(r);
      end
      ack_ok = bus.iack && (int'(bus.iack_vect) < N);
      for (int c = 0; c < N; c++) begin
        clr = (bus.reg_we && bus.reg_a == 3'd0 && bus.reg_di[c]) ||
              (ack_ok && int'(bus.iack_vect) == c);
        if (!m_mode[c])                np[c] = m_s2[c];
        else if (m_s2[c] && !m_s3[c]) np[c] = 1'b1;
        else if (clr)                  np[c] = 1'b0;
        else                           np[c] = m_pend[c];
      end
      m_pend = np;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq_in ^ ~m_pol;
      if (bus.reg_we) begin
        case (bus.reg_a)
          3'd1: m_en   = bus.reg_di[N-1:0];
          3'd2: m_mode = bus.reg_di[N-1:0];
          3'd3: m_pol  = bus.reg_di[N-1:0];
          3'd4: begin m_gie = bus.reg_di[0]; m_rr = bus.reg_di[1]; end
          default: ;
        endcase
      end
      if (ack_ok) m_ptr = (int'(bus.iack_vect) + 1) % N;
    end
  end

  // monitor: compare outputs and read data against queued expectations
  always @(negedge clk) begin
    if (out_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL out_q_empty t=%0t", $time);
    end else begin
      logic [VW:0] e;
      e = out_q.pop_front();
      checks++;
      if ({bus.iflag, bus.ivect} !== e) begin
        errors++;
        $display("FAIL iflag_ivect t=%0t act=%b exp=%b", $time, {bus.iflag, bus.ivect}, e);
      end
    end
    if (rd_q.size() > 0) begin
      rd_exp_t r;
      r = rd_q.pop_front();
      checks++;
      if (bus.reg_do !== r.mval) begin
        errors++;
        $display("FAIL read_model a=%0d t=%0t act=%h exp=%h", r.addr, $time, bus.reg_do, r.mval);
      end
      if (r.cmask != 8'h00) begin
        checks++;
        if ((bus.reg_do & r.cmask) !== (r.cval & r.cmask)) begin
          errors++;
          $display("FAIL read_const a=%0d t=%0t act=%h exp=%h mask=%h",
                   r.addr, $time, bus.reg_do, r.cval, r.cmask);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.reg_we = 1'b1; bus.reg_a = a; bus.reg_di = d;
    @(negedge clk);
    bus.reg_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] cv, input logic [7:0] cm);
    bus.reg_re = 1'b1; bus.reg_a = a; rd_cval = cv; rd_cmask = cm;
    @(negedge clk);
    bus.reg_re = 1'b0; rd_cmask = 8'h00;
  endtask

  task automatic ack(input int v);
    bus.iack = 1'b1; bus.iack_vect = VW'(v);
    @(negedge clk);
    bus.iack = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic f, input int v);
    chk({name, "_iflag"}, {7'd0, bus.iflag}, {7'd0, f});
    chk({name, "_ivect"}, 8'(bus.ivect), 8'(v));
  endtask

  initial begin
    int expv[3];
    irq_in = '0; rd_cval = 8'h00; rd_cmask = 8'h00;
    bus.reg_re = 1'b0; bus.reg_we = 1'b0; bus.reg_a = 3'd0; bus.reg_di = 8'h00;
    bus.iack = 1'b0; bus.iack_vect = '0;
    cyc(3);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // reset defaults
    chk_out("reset", 1'b0, 0);
    rd(3'd0, 8'h00, 8'hFF); rd(3'd1, 8'h00, 8'hFF); rd(3'd2, 8'h00, 8'hFF);
    rd(3'd3, 8'h0F, 8'hFF); rd(3'd4, 8'h00, 8'hFF); rd(3'd5, 8'h00, 8'hFF);
    rd(3'd6, 8'h00, 8'hFF);

    // edge capture on channel 2
    wr(3'd1, 8'h0F); wr(3'd2, 8'h0F); wr(3'd4, 8'h01);
    irq_in[2] = 1'b1; cyc(2); irq_in[2] = 1'b0; cyc(2);
    chk_out("edge_cap", 1'b1, 2);
    ack(2); cyc(1);
    chk_out("edge_ack", 1'b0, 0);
    rd(3'd0, 8'h00, 8'hFF);

    // level mode on channel 1
    wr(3'd2, 8'h00);
    irq_in[1] = 1'b1; cyc(4);
    chk_out("level_on", 1'b1, 1);
    ack(1); cyc(2);
    chk_out("level_after_ack", 1'b1, 1);
    irq_in[1] = 1'b0; cyc(4);
    chk_out("level_off", 1'b0, 0);

    // fixed priority then round-robin with channels 0 and 3 held
    irq_in = 4'b1001; cyc(4);
    chk_out("fixed_first", 1'b1, 0);
    repeat (3) begin
      ack(0); cyc(1);
      chk_out("fixed_reack", 1'b1, 0);
    end
    wr(3'd4, 8'h03); cyc(1);
    chk_out("rr_first", 1'b1, 3);
    expv[0] = 0; expv[1] = 3; expv[2] = 0;
    ack(3); cyc(1); chk_out("rr_wrap", 1'b1, expv[0]);
    ack(0); cyc(1); chk_out("rr_seq1", 1'b1, expv[1]);
    ack(3); cyc(1); chk_out("rr_seq2", 1'b1, expv[2]);
    irq_in = '0; wr(3'd4, 8'h01); cyc(4);

    // simultaneous edge set and W1C on channel 0
    wr(3'd2, 8'h0F); cyc(2); wr(3'd0, 8'h0F);
    irq_in[0] = 1'b1; cyc(2);
    wr(3'd0, 8'h01);
    rd(3'd0, 8'h01, 8'h01);
    irq_in[0] = 1'b0; cyc(4); wr(3'd0, 8'h0F); cyc(2);

    // active-low polarity on channel 0 and enable masking
    wr(3'd3, 8'h0E); cyc(3);
    rd(3'd5, 8'h01, 8'hFF);
    wr(3'd1, 8'h00); cyc(2);
    chk_out("masked", 1'b0, 0);
    rd(3'd0, 8'h01, 8'h01);
    wr(3'd1, 8'h0F); cyc(2);
    chk_out("unmasked", 1'b1, 0);

    // asynchronous reset while pending
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 1'b0, 0);
    chk("async_rst_reg_do", bus.reg_do, 8'h00);
    cyc(2);
    #2 rst_n = 1'b1;
    @(negedge clk);
    rd(3'd0, 8'h00, 8'hFF); rd(3'd3, 8'h0F, 8'hFF);

    // randomized traffic against the model
    wr(3'd1, 8'h0F); wr(3'd2, 8'(4'($urandom))); wr(3'd4, 8'h01);
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
      end
      bus.reg_a  = 3'($urandom);
      bus.reg_di = 8'($urandom);
      if (bus.reg_a == 3'd4 && $urandom_range(0, 3) != 0) bus.reg_di[0] = 1'b1;
      bus.reg_we = ($urandom_range(0, 7) == 0);
      bus.reg_re = ($urandom_range(0, 3) == 0);
      bus.iack   = ($urandom_range(0, 3) == 0);
      bus.iack_vect = VW'($urandom_range(0, N - 1));
      @(negedge clk);
    end
    bus.reg_we = 1'b0; bus.reg_re = 1'b0; bus.iack = 1'b0;
    cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
